// File: rtl/regfile_pkg.sv
// Shared defaults and address types for the register file with scoreboard.
package regfile_pkg;
   localparam int XLEN_DEF  = 32;
   localparam int NREGS_DEF = 32;
   localparam int AW_DEF    = $clog2(NREGS_DEF);

   typedef logic [AW_DEF-1:0] reg_addr_t;

   localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/regfile_sb_scoreboard.sv
// Pending-write scoreboard: issue sets a bit, writeback clears it, issue wins ties.
module reg_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS    = NREGS_DEF,
   parameter int ZERO_REG = 1,
   parameter int AW       = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             iss_en_i,
   input  logic [AW-1:0]    iss_addr_i,
   input  logic             wr_en_i,
   input  logic [AW-1:0]    wr_addr_i,
   output logic [NREGS-1:0] busy_vec_o
);

   logic [NREGS-1:0] busy_q, busy_d;

   always_comb begin
      busy_d = busy_q;
      for (int i = 0; i < NREGS; i++) begin
         // A newly issued producer supersedes the one retiring this cycle.
         if (iss_en_i && iss_addr_i == AW'(i))
            busy_d[i] = 1'b1;
         else if (wr_en_i && wr_addr_i == AW'(i))
            busy_d[i] = 1'b0;
      end
      if (ZERO_REG != 0)
         busy_d[int'(ZERO_ADDR)] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   assign busy_vec_o = busy_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with registered reads, write bypass and
// a per-register pending-write scoreboard.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter int XLEN     = XLEN_DEF,
   parameter int NREGS    = NREGS_DEF,
   parameter int AW       = $clog2(NREGS),
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             rd_en,
   input  logic [AW-1:0]    rs1_addr,
   input  logic [AW-1:0]    rs2_addr,
   output logic [XLEN-1:0]  rd1_data,
   output logic [XLEN-1:0]  rd2_data,
   output logic             rd1_busy,
   output logic             rd2_busy,
   output logic             rd_valid,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [XLEN-1:0]  wr_data,
   input  logic             iss_en,
   input  logic [AW-1:0]    iss_addr,
   output logic [NREGS-1:0] busy_vec
);

   logic [XLEN-1:0] regs_q [NREGS];
   logic            wr_ok;
   logic [XLEN:0]   rp1_d, rp2_d;
   logic [XLEN:0]   rp1_q, rp2_q;
   logic            vld_q;

   assign wr_ok = wr_en && !(ZERO_REG != 0 && wr_addr == AW'(ZERO_ADDR));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
      end else if (wr_ok) begin
         regs_q[wr_addr] <= wr_data;
      end
   end

   reg_scoreboard #(
      .NREGS    (NREGS),
      .ZERO_REG (ZERO_REG),
      .AW       (AW)
   ) u_sb (
      .clk        (clk),
      .rst_n      (rst_n),
      .iss_en_i   (iss_en),
      .iss_addr_i (iss_addr),
      .wr_en_i    (wr_en),
      .wr_addr_i  (wr_addr),
      .busy_vec_o (busy_vec)
   );

   // Returns {busy, data} for one read port as seen at the coming edge.
   function automatic logic [XLEN:0] read_port(input logic [AW-1:0] a);
      logic [XLEN:0] r;
      if (ZERO_REG != 0 && a == AW'(ZERO_ADDR))
         r = '0;
      else if (BYPASS != 0 && wr_ok && a == wr_addr)
         r = {iss_en && iss_addr == a, wr_data};
      else
         r = {busy_vec[a], regs_q[a]};
      return r;
   endfunction

   always_comb begin
      rp1_d = rp1_q;
      rp2_d = rp2_q;
      if (rd_en) begin
         rp1_d = read_port(rs1_addr);
         rp2_d = read_port(rs2_addr);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rp1_q <= '0;
         rp2_q <= '0;
         vld_q <= 1'b0;
      end else begin
         rp1_q <= rp1_d;
         rp2_q <= rp2_d;
         vld_q <= rd_en;
      end
   end

   assign {rd1_busy, rd1_data} = rp1_q;
   assign {rd2_busy, rd2_data} = rp2_q;
   assign rd_valid             = vld_q;

endmodule

// File: doc/regfile_sb.md
Name: regfile_sb

Overview:
- Parametrised successor to the core's 32x32 register file.
- Provides two registered read ports, one write port, and optional hardwired-zero x0.
- Adds write-to-read bypass and a per-register pending-write scoreboard for hazard detection.
- Sits between decode (reads, issue marking) and writeback (register write, pending clear) in the RISC-V datapath.

Parameters:
- XLEN, 32, data width of each register.
- NREGS, 32, number of architectural registers; power of two, at least 2.
- AW, $clog2(NREGS), address width (derived; do not override).
- ZERO_REG, 1, when 1 register 0 reads as zero, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write to a read address forwards wr_data to the read output.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- rd_en  in  1  read request; samples rs1_addr/rs2_addr this cycle.
- rs1_addr  in  AW  read port 1 address.
- rs2_addr  in  AW  read port 2 address.
- rd1_data  out  XLEN  read port 1 data, registered.
- rd2_data  out  XLEN  read port 2 data, registered.
- rd1_busy  out  1  registered pending flag for rs1_addr.
- rd2_busy  out  1  registered pending flag for rs2_addr.
- rd_valid  out  1  high exactly one cycle after an accepted rd_en.
- wr_en  in  1  writeback enable.
- wr_addr  in  AW  writeback address.
- wr_data  in  XLEN  writeback data.
- iss_en  in  1  issue: mark iss_addr as pending.
- iss_addr  in  AW  destination of the issued instruction.
- busy_vec  out  NREGS  current scoreboard, bit i = register i pending.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on rst_n.
- Reset values:
  - All registers 0; busy_vec 0.
  - rd1_data, rd2_data 0; rd1_busy, rd2_busy 0; rd_valid 0.
  - Reset asserted mid-operation clears everything immediately, without waiting for a clock edge.
- Write:
  - On a rising edge with wr_en=1, R[wr_addr] <= wr_data.
  - With ZERO_REG=1 and wr_addr=0 the write is dropped.
- Read (latency 1):
  - On a rising edge with rd_en=1, rdN_data <= R[rsN_addr] and rdN_busy <= busy_vec[rsN_addr]. rd_valid <= rd_en.
  - When rd_en=0, rdN_data and rdN_busy hold their previous values and rd_valid goes to 0.
- Bypass:
  - BYPASS=1, rd_en & wr_en same cycle, rsN_addr==wr_addr (and not a dropped x0 write): rdN_data <= wr_data and rdN_busy <= 0, unless iss_en also targets that address (then 1).
  - BYPASS=0: the read returns the old register value and the old busy bit.
- Scoreboard, per register i, at the rising edge:
  - set if iss_en & iss_addr==i.
  - clear if wr_en & wr_addr==i.
  - set and clear in the same cycle: set wins, because a new producer supersedes the retiring one.
  - ZERO_REG=1: bit 0 is constant 0.
  - Writeback to a non-busy register is legal: data is written and the bit stays 0.
- Read-port busy sampling uses the pre-edge busy_vec, with the bypass exception above.
- Both read ports may hit the same address; both return identical data.
- ZERO_REG=1 and rsN_addr=0: data 0 and busy 0, regardless of any bypass.
- Out-of-range addresses cannot occur, since NREGS is a power of two.
- No X propagation after reset; no initial-block preloads in the RTL.

Decomposition:
- Shared package regfile_pkg:
  - default XLEN/NREGS localparams.
  - reg_addr_t type (AW bits).
  - ZERO_ADDR constant.
- Sub-module reg_scoreboard: owns busy_vec, with the iss/wr set-clear priority logic and ZERO_REG masking. The storage array, read muxes and bypass stay in regfile_sb.

Test Plan:
1. Reset:
   - Stimulus: assert rst_n=0 mid-stream with prior state busy_vec=0x0000_0006 and rd1_data=0x7.
   - Required response: all outputs 0 immediately, before the next clk. After release, rd_en reading x5 returns 0.
2. Write then read:
   - Stimulus: wr x3=0xDEADBEEF; next cycle rd_en with rs1=3, rs2=3.
   - Required response: one cycle later rd1_data=rd2_data=0xDEADBEEF and rd_valid=1; rd_valid=0 on the following idle cycle.
3. Bypass:
   - Stimulus: same cycle wr x7=0x1234 and rd_en rs1=7.
   - Required response: BYPASS=1 gives rd1_data=0x1234; BYPASS=0 gives the prior R7 value.
4. x0:
   - Stimulus: wr x0=0xFFFFFFFF and iss x0, then read rs1=0.
   - Required response: ZERO_REG=1 gives rd1_data=0, rd1_busy=0, busy_vec[0]=0. ZERO_REG=0 gives rd1_data=0xFFFFFFFF, busy_vec[0]=1.
5. Scoreboard:
   - Stimulus: iss x9; next cycle read rs2=9; then wr x9 together with iss x9 in the same cycle; then wr x9 alone.
   - Required response:
     - After iss: busy_vec[9]=1 and rd2_busy=1.
     - After simultaneous wr+iss: busy_vec[9] stays 1.
     - After wr alone: busy_vec[9]=0.
6. Parameter sweep:
   - Stimulus: XLEN=64, NREGS=16; write distinct 64-bit values to all 16 registers, read them back pairwise, and hold rd_en=0.
   - Required response: all values match; outputs hold their previous values while rd_en=0.
